// File: rtl/pipeline_control_unit.sv
// Pipeline hazard control: forwarding, load-use stall, branch flush, dmem wait/timeout.
// Optional perf counters under PIPE_CTRL_PERF_CNT_EN.
//
// Ports:
//   clk, reset (async active-low)
//   de_rs1/de_rs2/ex_rs1/ex_rs2/ex_rd/mem_rd/wb_rd : stage register indices
//   ex_result_src (01=load), ex_pc_src, mem_reg_write, wb_reg_write
//   mem_mem_req, dmem_ready : MEM-stage access and memory completion
//   if/de/ex/mem_stall, de/ex/wb_flush : pipeline control
//   ex_op1_forward/ex_op2_forward : 00 regfile, 01 wb, 10 mem
//   dmem_timeout : sticky error; stall_cycles/flush_events : perf counters
module pipeline_control_unit #(
  parameter int REG_ADDR_W   = 5,
  parameter int DMEM_TIMEOUT = 64,
  parameter int CNT_W        = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] de_rs1,
  input  logic [REG_ADDR_W-1:0] de_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rs1,
  input  logic [REG_ADDR_W-1:0] ex_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [1:0]            ex_result_src,
  input  logic                  ex_pc_src,
  input  logic                  mem_reg_write,
  input  logic                  wb_reg_write,
  input  logic                  mem_mem_req,
  input  logic                  dmem_ready,
  output logic                  if_stall,
  output logic                  de_stall,
  output logic                  ex_stall,
  output logic                  mem_stall,
  output logic                  de_flush,
  output logic                  ex_flush,
  output logic                  wb_flush,
  output logic [1:0]            ex_op1_forward,
  output logic [1:0]            ex_op2_forward,
  output logic                  dmem_timeout,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_events
);

  localparam int WCW =
    (DMEM_TIMEOUT < 2) ? 1 : $clog2(DMEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    DMEM_WAIT = 2'd1,
    ERROR     = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [WCW-1:0] wait_q, wait_d;
  logic           tmo_q, tmo_d;

  logic [1:0] fwd1, fwd2;
  logic       load_use;
  logic       hold;
  logic       c_hold, c_br, c_lu;

  always_comb begin
    fwd1 = 2'b00;
    if (ex_rs1 != '0) begin
      if (mem_reg_write && mem_rd == ex_rs1)
        fwd1 = 2'b10;
      else if (wb_reg_write && wb_rd == ex_rs1)
        fwd1 = 2'b01;
    end
    fwd2 = 2'b00;
    if (ex_rs2 != '0) begin
      if (mem_reg_write && mem_rd == ex_rs2)
        fwd2 = 2'b10;
      else if (wb_reg_write && wb_rd == ex_rs2)
        fwd2 = 2'b01;
    end
  end

  assign load_use = (ex_result_src == 2'b01) &&
                    (ex_rd != '0) &&
                    ((ex_rd == de_rs1) || (ex_rd == de_rs2));

  // Freeze whole pipe: in ERROR, or memory still busy
  // (either already waiting or a fresh request this cycle).
  assign hold = (state_q == ERROR) ||
                (!dmem_ready &&
                 ((state_q == DMEM_WAIT) || mem_mem_req));

  assign c_hold = hold;
  assign c_br   = !hold && ex_pc_src;
  assign c_lu   = !hold && !ex_pc_src && load_use;

  always_comb begin
    if_stall       = 1'b0;
    de_stall       = 1'b0;
    ex_stall       = 1'b0;
    mem_stall      = 1'b0;
    de_flush       = 1'b0;
    ex_flush       = 1'b0;
    wb_flush       = 1'b0;
    ex_op1_forward = (state_q == ERROR) ? 2'b00 : fwd1;
    ex_op2_forward = (state_q == ERROR) ? 2'b00 : fwd2;
    unique case (1'b1)
      c_hold: begin
        if_stall  = 1'b1;
        de_stall  = 1'b1;
        ex_stall  = 1'b1;
        mem_stall = 1'b1;
        wb_flush  = 1'b1;
      end
      c_br: begin
        de_flush = 1'b1;
        ex_flush = 1'b1;
      end
      c_lu: begin
        if_stall = 1'b1;
        de_stall = 1'b1;
        ex_flush = 1'b1;
      end
      default: ;
    endcase
  end

  // wait_q counts stalled memory cycles, including the
  // RUN cycle that first saw the request.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      RUN: begin
        wait_d = '0;
        if (mem_mem_req && !dmem_ready) begin
          state_d = DMEM_WAIT;
          wait_d  = WCW'(1);
        end
      end
      DMEM_WAIT: begin
        if (dmem_ready) begin
          state_d = RUN;
          wait_d  = '0;
        end else if (wait_q >= WCW'(DMEM_TIMEOUT - 1)) begin
          state_d = ERROR;
          tmo_d   = 1'b1;
        end else begin
          wait_d = wait_q + WCW'(1);
        end
      end
      ERROR: ;
      default: begin
        state_d = RUN;
        wait_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      wait_q  <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      tmo_q   <= tmo_d;
    end
  end

  assign dmem_timeout = tmo_q;

`ifdef PIPE_CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q, flush_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (if_stall && stall_q != '1)
        stall_q <= stall_q + CNT_W'(1);
      if (de_flush && flush_q != '1)
        flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign stall_cycles = stall_q;
  assign flush_events = flush_q;
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Bench for pipeline_control_unit: directed spec scenarios,
// then random stimulus against a behavioural reference model.
module tb_pipeline_control_unit;

  localparam int AW = 5;
  localparam int TO = 4;
  localparam int CW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [AW-1:0] de_rs1, de_rs2, ex_rs1, ex_rs2;
  logic [AW-1:0] ex_rd, mem_rd, wb_rd;
  logic [1:0]    ex_result_src;
  logic          ex_pc_src, mem_reg_write, wb_reg_write;
  logic          mem_mem_req, dmem_ready;
  logic          if_stall, de_stall, ex_stall, mem_stall;
  logic          de_flush, ex_flush, wb_flush;
  logic [1:0]    ex_op1_forward, ex_op2_forward;
  logic          dmem_timeout;
  logic [CW-1:0] stall_cycles, flush_events;

  pipeline_control_unit #(
    .REG_ADDR_W(AW), .DMEM_TIMEOUT(TO), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset),
    .de_rs1(de_rs1), .de_rs2(de_rs2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .ex_result_src(ex_result_src), .ex_pc_src(ex_pc_src),
    .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
    .mem_mem_req(mem_mem_req), .dmem_ready(dmem_ready),
    .if_stall(if_stall), .de_stall(de_stall),
    .ex_stall(ex_stall), .mem_stall(mem_stall),
    .de_flush(de_flush), .ex_flush(ex_flush), .wb_flush(wb_flush),
    .ex_op1_forward(ex_op1_forward), .ex_op2_forward(ex_op2_forward),
    .dmem_timeout(dmem_timeout),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: consecutive unserved memory cycles,
  // a dead flag once the timeout budget is spent, event totals.
  int         m_pend;
  bit         m_dead;
  int         m_stall, m_flush;
  logic [10:0] m_exp;

  function automatic logic [1:0] ref_fwd(input logic [AW-1:0] rs);
    if (rs == 0) return 2'd0;
    if (mem_reg_write && mem_rd == rs) return 2'd2;
    if (wb_reg_write && wb_rd == rs) return 2'd1;
    return 2'd0;
  endfunction

  function automatic bit mem_busy();
    return !dmem_ready && (m_pend > 0 || mem_mem_req);
  endfunction

  // {ifs,des,exs,mems,def,exf,wbf,f1[1:0],f2[1:0]}
  function automatic logic [10:0] ref_out();
    logic [6:0] c;
    bit lu;
    if (m_dead) return {7'b1111001, 4'b0000};
    lu = ex_result_src == 2'b01 && ex_rd != 0 &&
         (ex_rd == de_rs1 || ex_rd == de_rs2);
    if (mem_busy())     c = 7'b1111001;
    else if (ex_pc_src) c = 7'b0000110;
    else if (lu)        c = 7'b1100010;
    else                c = 7'b0000000;
    return {c, ref_fwd(ex_rs1), ref_fwd(ex_rs2)};
  endfunction

  function automatic int exp_cnt(input int v);
`ifdef PIPE_CTRL_PERF_CNT_EN
    return (v > 15) ? 15 : v;
`else
    return 0 * v;
`endif
  endfunction

  task automatic check_now(input string tag);
    #2;
    m_exp = ref_out();
    chk({tag, "_ctl"},
        {21'd0, if_stall, de_stall, ex_stall, mem_stall,
         de_flush, ex_flush, wb_flush,
         ex_op1_forward, ex_op2_forward},
        {21'd0, m_exp});
    chk({tag, "_tmo"}, {31'd0, dmem_timeout}, {31'd0, m_dead});
    chk({tag, "_scnt"}, {28'd0, stall_cycles}, exp_cnt(m_stall));
    chk({tag, "_fcnt"}, {28'd0, flush_events}, exp_cnt(m_flush));
  endtask

  task automatic tick();
    @(posedge clk);
    if (m_exp[10]) m_stall++;
    if (m_exp[6])  m_flush++;
    if (!m_dead) begin
      if (mem_busy()) begin
        m_pend++;
        if (m_pend >= TO) m_dead = 1;
      end else begin
        m_pend = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    de_rs1 = 0; de_rs2 = 0; ex_rs1 = 0; ex_rs2 = 0;
    ex_rd = 0; mem_rd = 0; wb_rd = 0;
    ex_result_src = 0; ex_pc_src = 0;
    mem_reg_write = 0; wb_reg_write = 0;
    mem_mem_req = 0; dmem_ready = 1;
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b0;
    m_pend = 0; m_dead = 0; m_stall = 0; m_flush = 0;
    check_now(tag);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic rand_in();
    de_rs1 = AW'($urandom_range(0, 3));
    de_rs2 = AW'($urandom_range(0, 3));
    ex_rs1 = AW'($urandom_range(0, 3));
    ex_rs2 = AW'($urandom_range(0, 3));
    ex_rd  = AW'($urandom_range(0, 3));
    mem_rd = AW'($urandom_range(0, 3));
    wb_rd  = AW'($urandom_range(0, 3));
    ex_result_src = 2'($urandom_range(0, 3));
    ex_pc_src     = ($urandom_range(0, 5) == 0);
    mem_reg_write = 1'($urandom);
    wb_reg_write  = 1'($urandom);
    mem_mem_req   = ($urandom_range(0, 2) == 0);
    dmem_ready    = ($urandom_range(0, 3) != 0);
  endtask

  initial begin
    idle();
    reset = 1'b1;
    @(negedge clk);
    do_reset("rst0");
    chk("rst_idle_stall", {31'd0, if_stall}, 32'd0);

    // forwarding
    idle();
    ex_rs1 = 5; mem_rd = 5; mem_reg_write = 1;
    wb_rd = 5; wb_reg_write = 1;
    check_now("fwd_mem");
    chk("fwd_mem_lit", {30'd0, ex_op1_forward}, 32'd2);
    tick();
    mem_reg_write = 0;
    check_now("fwd_wb");
    chk("fwd_wb_lit", {30'd0, ex_op1_forward}, 32'd1);
    tick();
    ex_rs1 = 0;
    check_now("fwd_x0");
    chk("fwd_x0_lit", {30'd0, ex_op1_forward}, 32'd0);
    tick();

    // load-use, then branch override
    idle();
    ex_result_src = 2'b01; ex_rd = 7; de_rs2 = 7;
    check_now("lu");
    chk("lu_lit", {28'd0, if_stall, de_stall, ex_flush, de_flush},
        32'b1110);
    tick();
    ex_pc_src = 1;
    check_now("lu_br");
    chk("lu_br_lit", {28'd0, if_stall, de_stall, ex_flush, de_flush},
        32'b0011);
    tick();

    // memory wait with a pending branch
    idle();
    mem_mem_req = 1; dmem_ready = 0; ex_pc_src = 1;
    for (int i = 0; i < 3; i++) begin
      check_now("mw");
      chk("mw_lit",
          {27'd0, if_stall, de_stall, ex_stall, mem_stall, wb_flush},
          32'b11111);
      chk("mw_noflush", {30'd0, de_flush, ex_flush}, 32'd0);
      tick();
    end
    dmem_ready = 1;
    check_now("mw_done");
    chk("mw_done_lit", {27'd0, if_stall, mem_stall, wb_flush,
                        de_flush, ex_flush}, 32'b00011);
    tick();
    idle();
    dmem_ready = 0;
    check_now("mw_run");
    chk("mw_run_lit", {31'd0, if_stall}, 32'd0);
    tick();

    // timeout, sticky error, counter saturation
    idle();
    mem_mem_req = 1; dmem_ready = 0;
    for (int i = 0; i < TO; i++) begin
      check_now("to_wait");
      tick();
    end
    chk("to_set", {31'd0, dmem_timeout}, 32'd1);
    idle();
    ex_rs1 = 3; mem_rd = 3; mem_reg_write = 1;
    for (int i = 0; i < 20; i++) begin
      check_now("err");
      tick();
    end
    chk("err_tmo_lit", {31'd0, dmem_timeout}, 32'd1);
    chk("err_fwd_lit", {30'd0, ex_op1_forward}, 32'd0);
`ifdef PIPE_CTRL_PERF_CNT_EN
    chk("sat_lit", {28'd0, stall_cycles}, 32'd15);
`else
    chk("nocnt_lit", {28'd0, stall_cycles}, 32'd0);
`endif
    do_reset("rst_err");
    chk("rst_err_tmo", {31'd0, dmem_timeout}, 32'd0);
    idle();
    dmem_ready = 0;
    check_now("post_rst");
    chk("post_rst_lit", {31'd0, wb_flush}, 32'd0);
    tick();

    // random traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      rand_in();
      if ($urandom_range(0, 59) == 0) begin
        do_reset("rnd_rst");
      end else begin
        check_now("rnd");
        tick();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
